interp_block_sequencer: RTL and testbench

- Control FSM that sequences one 8x8 subpixel-interpolation block through the input shift register, input mux, FIR_A/B/C bank and half-pixel shift registers.
- Replaces the free-running counters and threshold compares that drive load_in, sel, load_L and load_out today with explicit handshaked phases: fill, horizontal pass, vertical pass, done.
- Sits between the row fetch unit (upstream) and the output collector (downstream).

---
 rtl/interp_block_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_interp_block_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_block_sequencer.sv
// interp_block_sequencer
// Sequences one NUM_PIXEL x NUM_PIXEL subpixel-interpolation block through the
// input shift register, input mux, FIR bank and half-pixel shift registers:
// fill (rows from upstream), horizontal pass, drain, vertical pass, drain, done.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   start      request one block; honoured only in IDLE
//   row_valid  upstream row valid
//   row_ready  sequencer accepts a row this cycle
//   load_in    input shift register enable (row_valid & row_ready)
//   sel        row/column select to the input mux
//   load_L     capture FIR outputs into the temp shift registers
//   out_ready  downstream can absorb one output row FIR_LAT cycles from now
//   load_out   FIR outputs form a valid output row this cycle
//   phase      0 IDLE, 1 FILL, 2 HORIZ(+drain), 3 VERT(+drain, done)
//   busy       high in every state except IDLE
//   done       one-cycle pulse when the block completes
//
// All outputs are decoded from registered state (plus row_valid for load_in),
// so an asynchronous reset forces them low in the same cycle.
module interp_block_sequencer #(
    parameter int unsigned NUM_PIXEL = 8,
    parameter int unsigned TAP_EXT   = 7,
    parameter int unsigned FIR_LAT   = 3,
    parameter int unsigned SEL_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             row_valid,
    output logic             row_ready,
    output logic             load_in,
    output logic [SEL_W-1:0] sel,
    output logic             load_L,
    input  logic             out_ready,
    output logic             load_out,
    output logic [1:0]       phase,
    output logic             busy,
    output logic             done
);

    localparam int unsigned ROWS     = NUM_PIXEL + TAP_EXT;
    localparam int unsigned MAX_SEL  = ROWS + NUM_PIXEL - 1;
    localparam int unsigned CNT_W    = $clog2(ROWS + 1);
    localparam int unsigned STEP_MAX = (FIR_LAT > ROWS) ? FIR_LAT : ROWS;
    localparam int unsigned STEP_W   = $clog2(STEP_MAX + 1);

    // Elaboration-time sanity checks on the parameter set.
    if ((MAX_SEL >> SEL_W) != 0) begin : g_sel_too_narrow
        $error("SEL_W too narrow for the largest select value");
    end
    if (FIR_LAT < 2) begin : g_fir_lat_too_small
        $error("FIR_LAT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_HORIZ  = 3'd2,
        S_HDRAIN = 3'd3,
        S_VERT   = 3'd4,
        S_VDRAIN = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    row_cnt;
    logic [STEP_W-1:0]   step;
    logic [FIR_LAT-1:0]  pipe;
    logic                pipe_out;
    logic                issue;
    logic                step_en;

    assign pipe_out = pipe[FIR_LAT-1];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; step counts issues (HORIZ/VERT) or drain cycles.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_FILL;
            end
            S_FILL: begin
                if (row_valid && (row_cnt == CNT_W'(ROWS - 1))) state_nxt = S_HORIZ;
            end
            S_HORIZ: begin
                if (step == STEP_W'(ROWS - 1)) state_nxt = S_HDRAIN;
            end
            S_HDRAIN: begin
                if (step == STEP_W'(FIR_LAT - 1)) state_nxt = S_VERT;
            end
            S_VERT: begin
                if (out_ready && (step == STEP_W'(NUM_PIXEL - 1))) state_nxt = S_VDRAIN;
            end
            S_VDRAIN: begin
                if (step == STEP_W'(FIR_LAT - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode; pipe_out is attributed to load_L or load_out by pass.
    always_comb begin
        row_ready = 1'b0;
        load_in   = 1'b0;
        load_L    = 1'b0;
        load_out  = 1'b0;
        phase     = 2'd0;
        busy      = 1'b0;
        done      = 1'b0;
        issue     = 1'b0;
        step_en   = 1'b0;
        case (state)
            S_IDLE: begin
                phase = 2'd0;
            end
            S_FILL: begin
                phase     = 2'd1;
                busy      = 1'b1;
                row_ready = (row_cnt != CNT_W'(ROWS));
                load_in   = row_valid && row_ready;
            end
            S_HORIZ: begin
                phase   = 2'd2;
                busy    = 1'b1;
                issue   = 1'b1;
                step_en = 1'b1;
                load_L  = pipe_out;
            end
            S_HDRAIN: begin
                phase   = 2'd2;
                busy    = 1'b1;
                step_en = 1'b1;
                load_L  = pipe_out;
            end
            S_VERT: begin
                phase    = 2'd3;
                busy     = 1'b1;
                issue    = out_ready;
                step_en  = out_ready;
                load_out = pipe_out;
            end
            S_VDRAIN: begin
                phase    = 2'd3;
                busy     = 1'b1;
                step_en  = 1'b1;
                load_out = pipe_out;
            end
            S_DONE: begin
                phase = 2'd3;
                busy  = 1'b1;
                done  = 1'b1;
            end
            default: begin
                phase = 2'd0;
            end
        endcase
    end

    // Datapath: row counter, step counter, select register, issue delay pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt <= '0;
            step    <= '0;
            sel     <= '0;
            pipe    <= '0;
        end else begin
            pipe <= {pipe[FIR_LAT-2:0], issue};

            if (state != state_nxt) begin
                step <= '0;
            end else if (step_en) begin
                step <= step + STEP_W'(1);
            end

            if ((state == S_IDLE) && (state_nxt == S_FILL)) begin
                row_cnt <= '0;
            end else if (load_in && (row_cnt != CNT_W'(ROWS))) begin
                row_cnt <= row_cnt + CNT_W'(1);
            end

            // sel advances after each issue except the last of a pass, so
            // it holds the last issued value (or the stalled value).
            if ((state == S_IDLE) && (state_nxt == S_FILL)) begin
                sel <= '0;
            end else if ((state == S_HDRAIN) && (state_nxt == S_VERT)) begin
                sel <= SEL_W'(ROWS);
            end else if (issue && (state == state_nxt)) begin
                sel <= sel + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_interp_block_sequencer.sv
// Testbench for interp_block_sequencer: randomized and directed blocks checked
// cycle by cycle against a schedule computed from the block's phase rules.
module tb_interp_block_sequencer;

    localparam int unsigned NP   = 8;
    localparam int unsigned TE   = 7;
    localparam int unsigned FL   = 3;
    localparam int unsigned SW   = 8;
    localparam int unsigned ROWS = NP + TE;
    localparam int          MAXC = 400;

    logic          clk;
    logic          rst;
    logic          start;
    logic          row_valid;
    logic          row_ready;
    logic          load_in;
    logic [SW-1:0] sel;
    logic          load_L;
    logic          out_ready;
    logic          load_out;
    logic [1:0]    phase;
    logic          busy;
    logic          done;

    int total;
    int bad;
    int prev_sel;

    bit rv  [MAXC];
    bit orr [MAXC];
    bit st  [MAXC];

    interp_block_sequencer #(
        .NUM_PIXEL (NP),
        .TAP_EXT   (TE),
        .FIR_LAT   (FL),
        .SEL_W     (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .load_in   (load_in),
        .sel       (sel),
        .load_L    (load_L),
        .out_ready (out_ready),
        .load_out  (load_out),
        .phase     (phase),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_row_ready"}, -1, 32'(row_ready), 32'd0);
        chk({tag, "_load_in"},   -1, 32'(load_in),   32'd0);
        chk({tag, "_load_L"},    -1, 32'(load_L),    32'd0);
        chk({tag, "_load_out"},  -1, 32'(load_out),  32'd0);
        chk({tag, "_phase"},     -1, 32'(phase),     32'd0);
        chk({tag, "_busy"},      -1, 32'(busy),      32'd0);
        chk({tag, "_done"},      -1, 32'(done),      32'd0);
    endtask

    // Idle cycles with start low: nothing may move.
    task automatic idle_cycles(input int n, input string tag);
        start     = 1'b0;
        row_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_busy"},  i, 32'(busy),  32'd0);
            chk({tag, "_phase"}, i, 32'(phase), 32'd0);
            chk({tag, "_sel"},   i, 32'(sel),   32'(prev_sel));
            @(posedge clk);
            #1;
        end
    endtask

    // One block. mode: 0 steady, 1 alternating upstream gaps, 2 downstream
    // stall plus start pulses in VERT and DONE, 3 random everything.
    // Cycle 0 is the cycle where start is presented in IDLE.
    task automatic run_block(input int mode, input bit do_abort, input string tag);
        int f;
        int v;
        int dn;
        int cnt;
        int abort_c;
        int viss [NP];
        int n_li;
        int n_ll;
        int n_lo;
        int obs_done;
        int issued;
        bit e_rr;
        bit e_li;
        bit e_ll;
        bit e_lo;
        int e_sel;
        int e_ph;

        f = -1;
        cnt = 0;
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                1:       rv[c] = (c % 2) == 1;
                3:       rv[c] = ($urandom_range(0, 1) == 1) || (c > 100);
                default: rv[c] = 1'b1;
            endcase
            if (c >= 1 && f < 0 && rv[c]) begin
                cnt++;
                if (cnt == int'(ROWS)) f = c;
            end
        end
        // 15 rows, then 15 issues, then FL drain cycles before vertical starts.
        v = f + int'(ROWS) + int'(FL) + 1;
        cnt = 0;
        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                2:       orr[c] = !((c >= v + 3) && (c < v + 8));
                3:       orr[c] = ($urandom_range(0, 1) == 1) || (c > v + 60);
                default: orr[c] = 1'b1;
            endcase
            if (c >= v && cnt < int'(NP) && orr[c]) begin
                viss[cnt] = c;
                cnt++;
            end
        end
        dn = viss[NP-1] + int'(FL) + 1;
        for (int c = 0; c < MAXC; c++) begin
            if (c == 0)       st[c] = 1'b1;
            else if (c > dn)  st[c] = 1'b0;
            else if (mode == 3) st[c] = ($urandom_range(0, 3) == 0);
            else if (mode == 2) st[c] = (c == v + 1) || (c == v + 4) || (c == dn);
            else              st[c] = 1'b0;
        end
        abort_c = do_abort ? f + 5 : -1;

        n_li = 0;
        n_ll = 0;
        n_lo = 0;
        obs_done = -1;
        for (int c = 0; c <= dn + 2; c++) begin
            start     = st[c];
            row_valid = rv[c];
            out_ready = orr[c];
            if (c == abort_c) begin
                chk({tag, "_pre_abort_phase"}, c, 32'(phase), 32'd2);
                #2 rst = 1'b0;
                #1;
                chk_outputs_zero({tag, "_abort"});
                start = 1'b0;
                row_valid = 1'b0;
                out_ready = 1'b0;
                prev_sel = 0;
                break;
            end

            issued = 0;
            e_lo = 1'b0;
            for (int k = 0; k < int'(NP); k++) begin
                if (viss[k] < c) issued++;
                if (viss[k] + int'(FL) == c) e_lo = 1'b1;
            end
            e_rr = (c >= 1) && (c <= f);
            e_li = e_rr && rv[c];
            e_ll = (c >= f + 1 + int'(FL)) && (c <= f + int'(ROWS) + int'(FL));
            if (c == 0)                  e_sel = prev_sel;
            else if (c <= f)             e_sel = 0;
            else if (c <= f + int'(ROWS)) e_sel = c - f - 1;
            else if (c < v)              e_sel = int'(ROWS) - 1;
            else                         e_sel = int'(ROWS) + ((issued < int'(NP)) ? issued : int'(NP) - 1);
            if (c == 0 || c > dn)  e_ph = 0;
            else if (c <= f)       e_ph = 1;
            else if (c < v)        e_ph = 2;
            else                   e_ph = 3;

            @(negedge clk);
            chk({tag, "_row_ready"}, c, 32'(row_ready), 32'(e_rr));
            chk({tag, "_load_in"},   c, 32'(load_in),   32'(e_li));
            chk({tag, "_load_L"},    c, 32'(load_L),    32'(e_ll));
            chk({tag, "_load_out"},  c, 32'(load_out),  32'(e_lo));
            chk({tag, "_sel"},       c, 32'(sel),       32'(e_sel));
            chk({tag, "_phase"},     c, 32'(phase),     32'(e_ph));
            chk({tag, "_busy"},      c, 32'(busy),      32'((c >= 1) && (c <= dn)));
            chk({tag, "_done"},      c, 32'(done),      32'(c == dn));
            if (load_in)  n_li++;
            if (load_L)   n_ll++;
            if (load_out) n_lo++;
            if (done && obs_done < 0) obs_done = c;
            @(posedge clk);
            #1;
        end
        start = 1'b0;

        if (!do_abort) begin
            chk({tag, "_n_load_in"},  -1, 32'(n_li), 32'(ROWS));
            chk({tag, "_n_load_L"},   -1, 32'(n_ll), 32'(ROWS));
            chk({tag, "_n_load_out"}, -1, 32'(n_lo), 32'(NP));
            chk({tag, "_done_cycle"}, -1, 32'(obs_done), 32'(dn));
            prev_sel = int'(ROWS) + int'(NP) - 1;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        prev_sel  = 0;
        rst       = 1'b0;
        start     = 1'b0;
        row_valid = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        chk("reset_sel", -1, 32'(sel), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(10, "idle_after_reset");

        // Steady traffic: load_in cycles 1-15, load_L 19-33, load_out 37-44.
        run_block(0, 1'b0, "nominal");
        // Upstream gaps on every other cycle.
        run_block(1, 1'b0, "gaps");
        // Downstream stall after three vertical issues; start while busy.
        run_block(2, 1'b0, "stall");
        // Random gaps, stalls and stray start pulses.
        for (int i = 0; i < 3; i++) begin
            run_block(3, 1'b0, "random");
        end

        // Reset in the middle of the horizontal pass, then a fresh block.
        run_block(0, 1'b1, "abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        idle_cycles(20, "idle_after_abort");
        run_block(0, 1'b0, "after_abort");
        idle_cycles(5, "idle_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
